// File: rtl/branch_cmp_arbiter.sv
// Two-requester front end for a shared signed comparator: round-robin grant, one compare in flight.
// Accept in N -> response valid in N+2; the response holds until its owner takes it, and nothing new is accepted meanwhile.
module branch_cmp_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req0_op,
    input  logic [2:0]       req1_op,
    output logic [WIDTH-1:0] cmp_reg1,
    output logic [WIDTH-1:0] cmp_reg2,
    input  logic             cmp_ne,
    input  logic             cmp_ge,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic             rsp_taken,
    output logic             rsp_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_EQ = 3'b000;
    localparam logic [2:0] OP_NE = 3'b001;
    localparam logic [2:0] OP_LT = 3'b100;
    localparam logic [2:0] OP_GE = 3'b101;

    state_t           r_state;
    state_t           w_next;
    logic             r_prio;
    logic             r_owner;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_cmp_reg1;
    logic [WIDTH-1:0] r_cmp_reg2;
    logic             r_taken;
    logic             r_err;

    logic w_idle;
    logic w_grant1;
    logic w_accept;
    logic w_owner_rdy;
    logic w_taken_d;
    logic w_err_d;

    // Requester 1 wins if it is alone, or if both ask and the pointer favours it.
    assign w_idle      = (r_state == IDLE);
    assign w_grant1    = req1_valid && (!req0_valid || r_prio);
    assign w_accept    = w_idle && (req0_valid || req1_valid);
    assign w_owner_rdy = r_owner ? rsp1_ready : rsp0_ready;

    assign req0_ready = w_idle && req0_valid && !w_grant1;
    assign req1_ready = w_idle && w_grant1;

    assign cmp_reg1   = r_cmp_reg1;
    assign cmp_reg2   = r_cmp_reg2;
    assign rsp0_valid = (r_state == RESP) && !r_owner;
    assign rsp1_valid = (r_state == RESP) && r_owner;
    assign rsp_taken  = r_taken;
    assign rsp_err    = r_err;
    assign busy       = !w_idle;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = CMP;
            CMP:     w_next = RESP;
            RESP:    if (w_owner_rdy) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_taken_d = 1'b0;
        w_err_d   = 1'b0;
        case (r_op)
            OP_EQ:   w_taken_d = !cmp_ne;
            OP_NE:   w_taken_d = cmp_ne;
            OP_LT:   w_taken_d = !cmp_ge;
            OP_GE:   w_taken_d = cmp_ge;
            default: w_err_d   = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_prio     <= 1'b0;
            r_owner    <= 1'b0;
            r_op       <= 3'b000;
            r_cmp_reg1 <= '0;
            r_cmp_reg2 <= '0;
            r_taken    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_owner    <= w_grant1;
                r_prio     <= !w_grant1;
                r_cmp_reg1 <= w_grant1 ? req1_a : req0_a;
                r_cmp_reg2 <= w_grant1 ? req1_b : req0_b;
                r_op       <= w_grant1 ? req1_op : req0_op;
            end
            // Flags are only trusted while the latched operands have settled through the comparator.
            if (r_state == CMP) begin
                r_taken <= w_taken_d;
                r_err   <= w_err_d;
            end
        end
    end

endmodule

// File: tb/tb_branch_cmp_arbiter.sv
// Bench for branch_cmp_arbiter: table vectors, directed corner sequences and randomized rounds.
module tb_branch_cmp_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] cmp_reg1, cmp_reg2;
    logic        cmp_ne, cmp_ge;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic        rsp_taken, rsp_err, busy;
    logic        noise;

    int checks = 0;
    int errors = 0;
    logic m_prio;

    branch_cmp_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .cmp_reg1(cmp_reg1), .cmp_reg2(cmp_reg2),
        .cmp_ne(cmp_ne), .cmp_ge(cmp_ge),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_taken(rsp_taken), .rsp_err(rsp_err), .busy(busy)
    );

    // Shared comparator; noise corrupts the flags whenever they must not be used.
    always_comb begin
        cmp_ne = (cmp_reg1 != cmp_reg2) ^ noise;
        cmp_ge = ($signed(cmp_reg1) >= $signed(cmp_reg2)) ^ noise;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    typedef struct {
        int          k;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        exp_t;
        logic        exp_e;
    } vec_t;

    function automatic logic [1:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
        case (op)
            3'b000:  return {1'b0, a == b};
            3'b001:  return {1'b0, a != b};
            3'b100:  return {1'b0, $signed(a) < $signed(b)};
            3'b101:  return {1'b0, $signed(a) >= $signed(b)};
            default: return 2'b10;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One complete transaction starting at posedge+1; the non-granted requester (if any) stays valid.
    task automatic round(input logic [1:0] mask,
                         input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] op0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] op1,
                         input int delay, output logic ot, output logic oe);
        int k;
        logic [31:0] ea, eb;
        logic [1:0] exp;
        logic [1:0] own_vld;
        k = (mask == 2'b11) ? int'(m_prio) : (mask[1] ? 1 : 0);
        ea = (k == 1) ? a1 : a0;
        eb = (k == 1) ? b1 : b0;
        exp = ref_res(ea, eb, (k == 1) ? op1 : op0);
        own_vld = (k == 1) ? 2'b10 : 2'b01;
        req0_valid = mask[0]; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = mask[1]; req1_a = a1; req1_b = b1; req1_op = op1;
        rsp0_ready = (delay == 0); rsp1_ready = (delay == 0);
        noise = 1'b1;
        #1;
        chk("grant_rdy0", req0_ready, k == 0);
        chk("grant_rdy1", req1_ready, k == 1);
        @(posedge clk); #1;
        m_prio = (k == 0);
        noise = 1'b0;
        if (k == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        #1;
        chk("cmp_busy", busy, 1'b1);
        chk("cmp_rsp_vld", {rsp1_valid, rsp0_valid}, 2'b00);
        chk("cmp_reg1", cmp_reg1, ea);
        chk("cmp_reg2", cmp_reg2, eb);
        chk("cmp_no_rdy", {req1_ready, req0_ready}, 2'b00);
        @(posedge clk); #1;
        noise = 1'($urandom_range(0, 1));
        chk("rsp_vld", {rsp1_valid, rsp0_valid}, own_vld);
        chk("rsp_res", {rsp_err, rsp_taken}, exp);
        ot = rsp_taken;
        oe = rsp_err;
        for (int d = 1; d < delay; d++) begin
            if (k == 0) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
            @(posedge clk); #1;
            noise = ~noise;
            chk("hold_vld", {rsp1_valid, rsp0_valid}, own_vld);
            chk("hold_res", {rsp_err, rsp_taken}, exp);
            chk("hold_no_rdy", {req1_ready, req0_ready}, 2'b00);
        end
        if (k == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        @(posedge clk); #1;
        noise = 1'b0;
        chk("idle_busy", busy, 1'b0);
        chk("idle_rsp_vld", {rsp1_valid, rsp0_valid}, 2'b00);
        chk("next_rdy", (k == 0) ? req1_ready : req0_ready, mask == 2'b11);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rsp_vld"}, {rsp1_valid, rsp0_valid}, 2'b00);
        chk({tag, "_taken"}, rsp_taken, 1'b0);
        chk({tag, "_err"}, rsp_err, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_reg1"}, cmp_reg1, 32'h0);
        chk({tag, "_reg2"}, cmp_reg2, 32'h0);
    endtask

    vec_t vecs[14];
    logic t, e;
    logic [31:0] ra0, rb0, ra1, rb1;
    logic [2:0]  rop0, rop1;

    function automatic logic [2:0] rand_op();
        logic [2:0] legal [4];
        legal = '{3'b000, 3'b001, 3'b100, 3'b101};
        if ($urandom_range(0, 3) == 0) return 3'($urandom_range(0, 7));
        return legal[$urandom_range(0, 3)];
    endfunction

    initial begin
        vecs[0]  = '{0, 32'd5,        32'd5,        3'b000, 1'b1, 1'b0};
        vecs[1]  = '{1, 32'd5,        32'd6,        3'b000, 1'b0, 1'b0};
        vecs[2]  = '{0, 32'd5,        32'd6,        3'b001, 1'b1, 1'b0};
        vecs[3]  = '{1, 32'hFFFFFFFD, 32'd2,        3'b100, 1'b1, 1'b0};
        vecs[4]  = '{0, 32'd7,        32'd7,        3'b101, 1'b1, 1'b0};
        vecs[5]  = '{1, 32'd2,        32'hFFFFFFFD, 3'b100, 1'b0, 1'b0};
        vecs[6]  = '{0, 32'h80000000, 32'h80000000, 3'b000, 1'b1, 1'b0};
        vecs[7]  = '{1, 32'h80000000, 32'h80000000, 3'b101, 1'b1, 1'b0};
        vecs[8]  = '{0, 32'h80000000, 32'h7FFFFFFF, 3'b101, 1'b0, 1'b0};
        vecs[9]  = '{1, 32'h80000000, 32'h7FFFFFFF, 3'b100, 1'b1, 1'b0};
        vecs[10] = '{1, 32'd5,        32'd5,        3'b010, 1'b0, 1'b1};
        vecs[11] = '{0, 32'd1,        32'd2,        3'b111, 1'b0, 1'b1};
        vecs[12] = '{0, 32'd9,        32'd9,        3'b011, 1'b0, 1'b1};
        vecs[13] = '{1, 32'hFFFFFFFF, 32'd0,        3'b101, 1'b0, 1'b0};

        rst_n = 1'b0; noise = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        req0_op = '0; req1_op = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        m_prio = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table vectors, one requester at a time.
        foreach (vecs[i]) begin
            if (vecs[i].k == 0)
                round(2'b01, vecs[i].a, vecs[i].b, vecs[i].op, 32'd0, 32'd0, 3'b000, 0, t, e);
            else
                round(2'b10, 32'd0, 32'd0, 3'b000, vecs[i].a, vecs[i].b, vecs[i].op, 0, t, e);
            chk($sformatf("vec%0d_taken", i), t, vecs[i].exp_t);
            chk($sformatf("vec%0d_err", i), e, vecs[i].exp_e);
        end

        // Reset after a req0-only accept leaves the pointer favouring req1; reset must restore req0.
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'b000;
        rsp0_ready = 1'b1;
        #1;
        chk("abort_acc_rdy", req0_ready, 1'b1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("abort");
        rst_n = 1'b1;
        m_prio = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("abort_no_rsp", {rsp1_valid, rsp0_valid, busy}, 3'b000);
        end
        rsp0_ready = 1'b0;

        // Both valid: grants alternate 0,1,0,1.
        for (int r = 0; r < 4; r++) begin
            round(2'b11, 32'hFFFFFFFD, 32'd2, 3'b100, 32'd7, 32'd7, 3'b101, 0, t, e);
            chk("alt_owner_taken", t, 1'b1);
        end
        chk("alt_prio_back", m_prio, 1'b0);

        // Long response stall with req1 waiting; req1 must wait until after rsp0_ready.
        round(2'b11, 32'd4, 32'd3, 3'b101, 32'd0, 32'd1, 3'b000, 4, t, e);
        chk("stall_taken", t, 1'b1);
        chk("stall_err", e, 1'b0);
        round(2'b10, 32'd0, 32'd0, 3'b000, 32'd3, 32'd5, 3'b010, 2, t, e);
        chk("illegal_req1_err", {e, t}, 2'b10);

        // Randomized rounds against the transaction-level model.
        for (int r = 0; r < 60; r++) begin
            ra0 = $urandom; rb0 = ($urandom_range(0, 3) == 0) ? ra0 : $urandom;
            ra1 = $urandom; rb1 = ($urandom_range(0, 3) == 0) ? ra1 : 32'($urandom_range(0, 15)) - 32'd8;
            rop0 = rand_op(); rop1 = rand_op();
            round(2'($urandom_range(1, 3)), ra0, rb0, rop0, ra1, rb1, rop1,
                  $urandom_range(0, 3), t, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_cmp_arbiter.md
BRANCH_CMP_ARBITER -- requirements
Module: branch_cmp_arbiter

Interface
Parameters, one per line: name, default, meaning.
REQ-001 The block SHALL have parameter WIDTH, default 32: operand width in bits; operands are signed two's complement.

Ports, one per line: name, direction, width, meaning.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 The block SHALL have ports req0_valid and req1_valid, input, 1 each: requester 0 (branch unit) and requester 1 (ALU set-compare) request.
REQ-005 The block SHALL have ports req0_ready and req1_ready, output, 1 each: the request is accepted this cycle.
REQ-006 The block SHALL have ports req0_a, req0_b, req1_a and req1_b, input, WIDTH each: the operand pair of each requester.
REQ-007 The block SHALL have ports req0_op and req1_op, input, 3 each: compare op. 000 EQ, 001 NE, 100 LT, 101 GE; all other codes are illegal.
REQ-008 The block SHALL have ports cmp_reg1 and cmp_reg2, output, WIDTH each: registered operands driven to the shared comparator.
REQ-009 The block SHALL have ports cmp_ne and cmp_ge, input, 1 each: comparator flags (reg1!=reg2, reg1>=reg2 signed); combinational from cmp_reg1/cmp_reg2.
REQ-010 The block SHALL have ports rsp0_valid and rsp1_valid, output, 1 each: the result for that requester is valid.
REQ-011 The block SHALL have ports rsp0_ready and rsp1_ready, input, 1 each: the requester consumes its result.
REQ-012 The block SHALL have port rsp_taken, output, 1: the compare result, shared by both responses.
REQ-013 The block SHALL have port rsp_err, output, 1: the op was illegal.
REQ-014 The block SHALL have port busy, output, 1: the FSM is not in IDLE.

Function
REQ-015 The FSM SHALL have exactly 3 states, encoded IDLE, CMP and RESP.
REQ-016 In IDLE, the block SHALL grant one requester that has valid high; if both are high, it SHALL grant the requester selected by the priority pointer prio (0 or 1).
REQ-017 The block SHALL drive reqK_ready combinationally, high only when state==IDLE and K is the granted requester; at most one ready SHALL be high per cycle.
REQ-018 On accept (valid&&ready), the block SHALL latch a→cmp_reg1, b→cmp_reg2, op→op_q and K→owner, then go to CMP.
REQ-019 In CMP, the block SHALL register the result from cmp_ne/cmp_ge, then go to RESP:
  - EQ → taken=~ne
  - NE → taken=ne
  - LT → taken=~ge
  - GE → taken=ge
  - illegal op → taken=0, err=1; legal op → err=0.
REQ-020 In RESP, the block SHALL hold rsp<owner>_valid=1 with rsp_taken and rsp_err stable until rsp<owner>_ready=1, then go to IDLE.
REQ-021 The non-owner rsp_valid SHALL stay 0 at all times.
REQ-022 Latency: accept in cycle N SHALL give rsp_valid in cycle N+2; if rsp_ready is already high, the block SHALL return to IDLE in N+3 and may accept a new request there.
REQ-023 Throughput SHALL be at most one compare per 3 cycles; the block SHALL NOT overlap transactions.
REQ-024 Round-robin: on each accept, prio SHALL be set to the requester not granted; if only one requester is valid, it SHALL be granted regardless of prio.
REQ-025 cmp_reg1 and cmp_reg2 SHALL change only on accept and SHALL hold their value in CMP and RESP.
REQ-026 While valid and not ready, a requester holds a, b and op stable; the block SHALL NOT sample them until accept.
REQ-027 Arithmetic SHALL be signed WIDTH-bit with no extension or truncation; the case a=b=most-negative value SHALL give EQ taken=1 and GE taken=1.
REQ-028 rsp_ready asserted outside RESP, or by the non-owner, SHALL have no effect.
REQ-029 Flags SHALL be sampled only in CMP; flag changes in IDLE or RESP SHALL NOT alter the result.

Reset
REQ-030 When rst_n=0 at a clock edge, the block SHALL set: state=IDLE, prio=0, owner=0, cmp_reg1=0, cmp_reg2=0, op_q=000, taken=0, err=0.
REQ-031 During and after reset, all rsp_valid, rsp_taken, rsp_err and busy SHALL read 0.
REQ-032 Reset mid-transaction (in CMP or RESP) SHALL abort it with no response delivered; the first accept after reset SHALL favour requester 0.

Verification
REQ-033 Scenario: req0 only, a=5, b=5, op=000, rsp0_ready=1 → req0_ready in N, rsp0_valid in N+2, taken=1, err=0, busy low in N+3.
REQ-034 Scenario: both valid after reset; req0 a=-3, b=2, op=100; req1 a=7, b=7, op=101 → req0 granted first with taken=1; req1 granted next with taken=1; prio alternates.
REQ-035 Scenario: req1 op=010 → rsp1_valid with taken=0, err=1.
REQ-036 Scenario: rsp0_ready held low for 4 cycles in RESP → rsp0_valid, taken and err stable; req1 not accepted until the cycle after rsp0_ready=1.
REQ-037 Scenario: rst_n=0 while in CMP → next cycle state is IDLE with all outputs 0; no rsp_valid is ever asserted for the aborted request.
REQ-038 Scenario: a=32'h80000000, b=32'h7FFFFFFF, op=101 → taken=0; op=100 → taken=1.
